touch_adc_reader: RTL

- SPI master for the resistive touch-panel ADC (ADS7843/XPT2046-class). Periodically reads raw 12-bit X/Y, scales them to 640x480 screen space, and debounces press/release.
- Produces the tor_x/tor_y/clcount stream that the on-screen button hit-detect blocks consume.
- Sits between the touch-panel pins and all touch-region logic.

---
 rtl/touch_adc_reader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/touch_adc_reader.sv
// Periodic SPI reader for an ADS7843/XPT2046-class touch ADC: scales raw X/Y to
// 640x480 screen space and debounces pen press/release into the clcount phase.
module touch_adc_reader #(
    parameter int         CLK_DIV         = 25,
    parameter int         SCAN_PERIOD     = 50000,
    parameter int         PRESS_SAMPLES   = 3,
    parameter int         RELEASE_SAMPLES = 3,
    parameter logic [7:0] CMD_X           = 8'hD0,
    parameter logic [7:0] CMD_Y           = 8'h90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ts_penirq_n,
    input  logic       ts_dout,
    output logic       ts_cs_n,
    output logic       ts_sclk,
    output logic       ts_din,
    output logic [9:0] tor_x,
    output logic [8:0] tor_y,
    output logic       valid,
    output logic [1:0] clcount,
    output logic       busy
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int TMR_W = $clog2(SCAN_PERIOD + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SCAN_PERIOD - 1);
    localparam logic [7:0]       PRESS_N   = 8'(PRESS_SAMPLES);
    localparam logic [7:0]       RELEASE_N = 8'(RELEASE_SAMPLES);

    typedef enum logic [2:0] {IDLE, CHECK, XFER_X, XFER_Y, UPDATE} state_t;

    state_t           state, state_nxt;
    logic             penirq_p0, penirq_p1, dout_p0, dout_p1;
    logic [TMR_W-1:0] timer;
    logic [DIV_W-1:0] div;
    logic [5:0]       hs, hs_next;
    logic [7:0]       down_cnt, up_cnt, down_inc, up_inc;
    logic             pressed;
    logic [7:0]       cmd_sr;
    logic [11:0]      shreg, raw_x;
    logic             tick, xfer, half_tick, xfer_done, capture, pen_down;

    function automatic logic [9:0] scale_x(input logic [11:0] raw);
        logic [14:0] prod;
        prod = {3'b000, raw} * 15'd5;
        return prod[14:5];
    endfunction

    function automatic logic [8:0] scale_y(input logic [11:0] raw);
        logic [15:0] prod;
        prod = {4'b0000, raw} * 16'd15;
        return prod[15:7];
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic [7:0] lim);
        return (cnt >= lim) ? lim : cnt + 8'd1;
    endfunction

    // Transaction = 50 half-period steps: 24 SCLK pulses (steps 1..48), cs_n rise (49), gap (50)
    assign tick      = enable && (timer == TMR_LAST);
    assign xfer      = (state == XFER_X) || (state == XFER_Y);
    assign half_tick = xfer && (div == DIV_LAST);
    assign hs_next   = hs + 6'd1;
    assign xfer_done = half_tick && (hs == 6'd49);
    assign capture   = half_tick && hs_next[0] && (hs_next >= 6'd19) && (hs_next <= 6'd41);
    assign pen_down  = ~penirq_p1;
    assign down_inc  = sat_inc(down_cnt, PRESS_N);
    assign up_inc    = sat_inc(up_cnt, RELEASE_N);
    assign busy      = ~ts_cs_n;

    // Stage p0/p1: two-flop synchronisers for the ADC inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            penirq_p0 <= 1'b1;
            penirq_p1 <= 1'b1;
            dout_p0   <= 1'b0;
            dout_p1   <= 1'b0;
        end else begin
            penirq_p0 <= ts_penirq_n;
            penirq_p1 <= penirq_p0;
            dout_p0   <= ts_dout;
            dout_p1   <= dout_p0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= (!enable || tick) ? '0 : timer + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = CHECK;
            CHECK:   state_nxt = pen_down ? XFER_X : IDLE;
            XFER_X:  if (xfer_done) state_nxt = XFER_Y;
            XFER_Y:  if (xfer_done) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift registers carry data only and need no reset
    always_ff @(posedge clk) begin
        if (state == CHECK)
            cmd_sr <= {CMD_X[6:0], 1'b0};
        else if (xfer_done && state == XFER_X)
            cmd_sr <= {CMD_Y[6:0], 1'b0};
        else if (half_tick && !hs_next[0] && hs_next <= 6'd48)
            cmd_sr <= {cmd_sr[6:0], 1'b0};
        if (capture)
            shreg <= {shreg[10:0], dout_p1};
        if (xfer_done && state == XFER_X)
            raw_x <= shreg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_cs_n  <= 1'b1;
            ts_sclk  <= 1'b0;
            ts_din   <= 1'b0;
            div      <= '0;
            hs       <= '0;
            tor_x    <= '0;
            tor_y    <= '0;
            valid    <= 1'b0;
            clcount  <= 2'd0;
            down_cnt <= '0;
            up_cnt   <= '0;
            pressed  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clcount == 2'd1)
                clcount <= 2'd2;
            else if (clcount == 2'd3)
                clcount <= 2'd0;
            div <= '0;
            hs  <= '0;
            if (xfer) begin
                div <= half_tick ? '0 : div + 1'b1;
                hs  <= half_tick ? (xfer_done ? 6'd0 : hs_next) : hs;
            end
            case (state)
                CHECK: begin
                    if (pen_down) begin
                        down_cnt <= down_inc;
                        up_cnt   <= '0;
                        ts_cs_n  <= 1'b0;
                        ts_din   <= CMD_X[7];
                    end else begin
                        up_cnt   <= up_inc;
                        down_cnt <= '0;
                        if (pressed && up_inc >= RELEASE_N) begin
                            pressed <= 1'b0;
                            clcount <= 2'd3;
                        end
                    end
                end
                XFER_X, XFER_Y: begin
                    if (half_tick) begin
                        if (xfer_done) begin
                            if (state == XFER_X) begin
                                ts_cs_n <= 1'b0;
                                ts_din  <= CMD_Y[7];
                            end
                        end else if (hs_next == 6'd49) begin
                            ts_cs_n <= 1'b1;
                        end else if (hs_next[0]) begin
                            ts_sclk <= 1'b1;
                        end else begin
                            ts_sclk <= 1'b0;
                            ts_din  <= cmd_sr[7];
                        end
                    end
                end
                UPDATE: begin
                    tor_x <= scale_x(raw_x);
                    tor_y <= scale_y(shreg);
                    valid <= 1'b1;
                    if (!pressed && down_cnt >= PRESS_N) begin
                        pressed <= 1'b1;
                        clcount <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
